multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control FSM that sequences the RV32I datapath (instruction register, register file, immediate generator, ALU, data memory, PC) through fetch/decode/execute/memory/writeback phases. It decodes the latched opcode for the R, I, L, S and B instruction classes and emits per-cycle write enables, mux selects and memory handshakes. It also keeps a retired-instruction counter and a sticky illegal-opcode trap. It sits beside the datapath; the immediate generator decodes its own format from the same instruction register.

## Interface
- `XLEN`, 32, width of `retired_count`
- `clk` input 1 — rising-edge clock
- `rst_n` input 1 — asynchronous active-low reset
- `opcode` input 7 — instruction[6:0] from the instruction register; valid from DECODE onward
- `funct3` input 3 — instruction[14:12]
- `alu_zero`, `alu_lt`, `alu_ltu` input 1 each — ALU compare flags, valid in EXEC
- `imem_ready` input 1 — instruction memory has data this cycle
- `dmem_ready` input 1 — data memory completes the access this cycle
- `imem_req` output 1 — instruction fetch request
- `ir_we` output 1 — load instruction register
- `pc_we` output 1 — update PC
- `pc_src_branch` output 1 — PC takes branch target (PC+imm), else PC+4
- `alu_src_imm` output 1 — ALU operand B is the immediate
- `alu_op` output 2 — 00 ADD (address), 01 funct-decoded, 10 compare
- `dmem_re`, `dmem_we` output 1 each — data read/write request
- `reg_we` output 1 — register file write
- `wb_sel_mem` output 1 — writeback source is memory, else ALU
- `retire` output 1 — one-cycle pulse per completed instruction
- `retired_count` output XLEN — completed-instruction count
- `trap` output 1 — sticky illegal-instruction flag

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP (3-bit encoding).
- Opcodes are taken from `defines.vh`: `R_type` 0110011, `I_type` 0010011, `L_type` 0000011, `S_type` 0100011, `B_type` 1100011.
- IDLE: all outputs 0. Goes to FETCH unconditionally on the next edge.
- FETCH: `imem_req`=1 and `ir_we`=`imem_ready`.
  - Stays in FETCH while `imem_ready`=0.
  - Goes to DECODE when `imem_ready`=1.
- DECODE: all outputs 0.
  - Goes to EXEC if the opcode is one of the five supported classes.
  - Goes to TRAP for any other opcode.
  - Goes to TRAP for B_type with funct3 010 or 011.
- EXEC outputs by class:
  - R: `alu_op`=01, `alu_src_imm`=0.
  - I: `alu_op`=01, `alu_src_imm`=1.
  - L and S: `alu_op`=00, `alu_src_imm`=1.
  - B: `alu_op`=10, `alu_src_imm`=0, `pc_we`=1, `retire`=1.
- EXEC branch condition, which drives `pc_src_branch`:
  - funct3 000: `alu_zero`
  - 001: !`alu_zero`
  - 100: `alu_lt`
  - 101: !`alu_lt`
  - 110: `alu_ltu`
  - 111: !`alu_ltu`
- EXEC next state: R and I go to WB; L and S go to MEM; B goes to FETCH.
- MEM:
  - L: `dmem_re`=1.
  - S: `dmem_we`=1. Also `pc_we`=`retire`=`dmem_ready`.
  - Stays in MEM while `dmem_ready`=0.
  - On `dmem_ready`, L goes to WB and S goes to FETCH.
  - `alu_op`=00 and `alu_src_imm`=1 are held throughout MEM.
- WB: `reg_we`=1, `pc_we`=1, `retire`=1, `wb_sel_mem`=(class==L). Goes to FETCH.
- TRAP: absorbing state. `trap`=1, all other outputs 0. Only reset exits it.
- `retired_count`: increments by 1 on each edge where `retire`=1. Wraps from 2^XLEN−1 to 0.
- Outputs not listed for a state are 0. All outputs except `retired_count` are combinational from state and inputs.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - State goes to IDLE immediately.
  - `retired_count`=0, `trap`=0.
  - All other outputs are 0 while reset is held.
- First `imem_req` is asserted one cycle after `rst_n` deasserts.
- Minimum cycles per instruction, with ready inputs high: R/I 4, B 3, S 4, L 5. Each ready-low cycle adds one cycle.
- `pc_we` asserts exactly once per instruction, in the same cycle as `retire`.
- `ir_we` asserts exactly once per instruction.
- `imem_ready` is ignored outside FETCH. `dmem_ready` is ignored outside MEM.
- Reset asserted mid-MEM drops `dmem_re`/`dmem_we` in the same cycle. No retire is counted for that instruction.

## Test plan
- Reset, then one ADDI (0010011) with `imem_ready`=1 → states IDLE, FETCH, DECODE, EXEC, WB, FETCH. `reg_we`=`pc_we`=`retire`=1 only in WB. `retired_count`=1.
- LW with `dmem_ready` low for 3 MEM cycles → `dmem_re` high for 4 cycles, then WB with `wb_sel_mem`=1. CPI 8. Count increments by 1.
- SW with `dmem_ready`=1 → `dmem_we` and `pc_we` pulse together in MEM. `reg_we` never asserts. Next state is FETCH.
- BEQ with `alu_zero`=1, then BNE with `alu_zero`=1 → `pc_src_branch` 1 then 0. Each takes 3 cycles.
- Opcode 1111111, and separately B_type with funct3=010 → TRAP. `trap` stays 1 for 100 cycles and the count is frozen. `rst_n` low clears it to IDLE with count 0.
- Preload the count to 2^XLEN−1 by forcing it, then retire one instruction → `retired_count`=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// emits datapath strobes, counts retired instructions and traps on illegal opcodes.
module multicycle_controller #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            alu_zero,
    input  logic            alu_lt,
    input  logic            alu_ltu,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    output logic            imem_req,
    output logic            ir_we,
    output logic            pc_we,
    output logic            pc_src_branch,
    output logic            alu_src_imm,
    output logic [1:0]      alu_op,
    output logic            dmem_re,
    output logic            dmem_we,
    output logic            reg_we,
    output logic            wb_sel_mem,
    output logic            retire,
    output logic [XLEN-1:0] retired_count,
    output logic            trap
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_FUNC = 2'b01;
    localparam logic [1:0] ALU_CMP  = 2'b10;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] retired_count_q;

    logic is_r, is_i, is_l, is_s, is_b, b_legal, legal, branch_taken;

    // The instruction register only loads in FETCH, so the opcode stays stable
    // from DECODE to the end of the instruction and needs no local copy.
    assign is_r    = (opcode == OP_R);
    assign is_i    = (opcode == OP_I);
    assign is_l    = (opcode == OP_L);
    assign is_s    = (opcode == OP_S);
    assign is_b    = (opcode == OP_B);
    assign b_legal = is_b && (funct3 != 3'b010) && (funct3 != 3'b011);
    assign legal   = is_r || is_i || is_l || is_s || b_legal;

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = alu_zero;
            3'b001:  branch_taken = !alu_zero;
            3'b100:  branch_taken = alu_lt;
            3'b101:  branch_taken = !alu_lt;
            3'b110:  branch_taken = alu_ltu;
            3'b111:  branch_taken = !alu_ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output and next-state gets a default before the case so no
        // path leaves a value unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        imem_req      = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src_branch = 1'b0;
        alu_src_imm   = 1'b0;
        alu_op        = ALU_ADD;
        dmem_re       = 1'b0;
        dmem_we       = 1'b0;
        reg_we        = 1'b0;
        wb_sel_mem    = 1'b0;
        retire        = 1'b0;
        trap          = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
                if (imem_ready) state_d = S_DECODE;
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_r || is_i) begin
                    alu_op      = ALU_FUNC;
                    alu_src_imm = is_i;
                    state_d     = S_WB;
                end else if (is_l || is_s) begin
                    alu_src_imm = 1'b1;
                    state_d     = S_MEM;
                end else begin
                    alu_op        = ALU_CMP;
                    pc_we         = 1'b1;
                    retire        = 1'b1;
                    pc_src_branch = branch_taken;
                    state_d       = S_FETCH;
                end
            end
            S_MEM: begin
                alu_src_imm = 1'b1;
                dmem_re     = is_l;
                dmem_we     = is_s;
                pc_we       = is_s && dmem_ready;
                retire      = is_s && dmem_ready;
                if (dmem_ready) state_d = is_l ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                retire     = 1'b1;
                wb_sel_mem = is_l;
                state_d    = S_FETCH;
            end
            S_TRAP:  trap = 1'b1;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            retired_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            if (retire) retired_count_q <= retired_count_q + {{(XLEN-1){1'b0}}, 1'b1};
        end
    end

    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by
// cycle against hand-computed strobe vectors, then traps, resets and count wrap.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alu_zero, alu_lt, alu_ltu, imem_ready, dmem_ready;
    logic        imem_req, ir_we, pc_we, pc_src_branch, alu_src_imm;
    logic [1:0]  alu_op;
    logic        dmem_re, dmem_we, reg_we, wb_sel_mem, retire, trap;
    logic [31:0] retired_count;

    int checks = 0;
    int failures = 0;

    multicycle_controller #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src_branch(pc_src_branch), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .reg_we(reg_we),
        .wb_sel_mem(wb_sel_mem), .retire(retire), .retired_count(retired_count),
        .trap(trap)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

    // Vector order: imem_req ir_we pc_we pc_src_branch alu_src_imm alu_op[1:0]
    //               dmem_re dmem_we reg_we wb_sel_mem retire trap
    localparam logic [12:0] O_ZERO    = 13'b0_0_0_0_0_00_0_0_0_0_0_0;
    localparam logic [12:0] O_FETCH_W = 13'b1_1_0_0_0_00_0_0_0_0_0_0;
    localparam logic [12:0] O_FETCH_S = 13'b1_0_0_0_0_00_0_0_0_0_0_0;
    localparam logic [12:0] O_EX_I    = 13'b0_0_0_0_1_01_0_0_0_0_0_0;
    localparam logic [12:0] O_EX_R    = 13'b0_0_0_0_0_01_0_0_0_0_0_0;
    localparam logic [12:0] O_EX_LS   = 13'b0_0_0_0_1_00_0_0_0_0_0_0;
    localparam logic [12:0] O_MEM_L   = 13'b0_0_0_0_1_00_1_0_0_0_0_0;
    localparam logic [12:0] O_MEM_S   = 13'b0_0_1_0_1_00_0_1_0_0_1_0;
    localparam logic [12:0] O_WB_ALU  = 13'b0_0_1_0_0_00_0_0_1_0_1_0;
    localparam logic [12:0] O_WB_MEM  = 13'b0_0_1_0_0_00_0_0_1_1_1_0;
    localparam logic [12:0] O_EX_B_T  = 13'b0_0_1_1_0_10_0_0_0_0_1_0;
    localparam logic [12:0] O_EX_B_N  = 13'b0_0_1_0_0_10_0_0_0_0_1_0;
    localparam logic [12:0] O_TRAP    = 13'b0_0_0_0_0_00_0_0_0_0_0_1;

    wire [12:0] outs = {imem_req, ir_we, pc_we, pc_src_branch, alu_src_imm, alu_op,
                        dmem_re, dmem_we, reg_we, wb_sel_mem, retire, trap};

    task automatic check_outs(input string tag, input logic [2:0] st, input logic [12:0] ex);
        checks++;
        assert (dut.state_q === st && outs === ex) else begin
            failures++;
            $error("FAIL %s: state=%0d outs=%b required state=%0d outs=%b",
                   tag, dut.state_q, outs, st, ex);
        end
    endtask

    task automatic check_count(input string tag, input logic [31:0] ex);
        checks++;
        assert (retired_count === ex) else begin
            failures++;
            $error("FAIL %s: retired_count=%0h required %0h", tag, retired_count, ex);
        end
    endtask

    // Called at a falling edge with inputs already driven: check, then advance.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [12:0] ex);
        #1;
        check_outs(tag, st, ex);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'b0010011; funct3 = 3'b000;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (2) @(negedge clk);
        cyc("reset_held", S_IDLE, O_ZERO);
        check_count("reset_count", 32'd0);

        // ADDI
        rst_n = 1'b1;
        cyc("addi_idle", S_IDLE, O_ZERO);
        cyc("addi_fetch", S_FETCH, O_FETCH_W);
        cyc("addi_decode", S_DECODE, O_ZERO);
        cyc("addi_exec", S_EXEC, O_EX_I);
        cyc("addi_wb", S_WB, O_WB_ALU);
        #1 check_count("addi_count", 32'd1);

        // LW with three wait cycles
        opcode = 7'b0000011; funct3 = 3'b010;
        cyc("lw_fetch", S_FETCH, O_FETCH_W);
        cyc("lw_decode", S_DECODE, O_ZERO);
        cyc("lw_exec", S_EXEC, O_EX_LS);
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", S_MEM, O_MEM_L);
        dmem_ready = 1'b1;
        cyc("lw_mem_done", S_MEM, O_MEM_L);
        cyc("lw_wb", S_WB, O_WB_MEM);
        #1 check_count("lw_count", 32'd2);

        // SW with one instruction-memory stall; dmem_ready high outside MEM is ignored
        opcode = 7'b0100011;
        imem_ready = 1'b0;
        cyc("sw_fetch_stall", S_FETCH, O_FETCH_S);
        imem_ready = 1'b1;
        cyc("sw_fetch", S_FETCH, O_FETCH_W);
        cyc("sw_decode", S_DECODE, O_ZERO);
        cyc("sw_exec", S_EXEC, O_EX_LS);
        cyc("sw_mem", S_MEM, O_MEM_S);
        #1 check_outs("sw_next", S_FETCH, O_FETCH_W);
        check_count("sw_count", 32'd3);

        // BEQ taken, BNE not taken, BLTU taken
        opcode = 7'b1100011; funct3 = 3'b000; alu_zero = 1'b1;
        cyc("beq_fetch", S_FETCH, O_FETCH_W);
        cyc("beq_decode", S_DECODE, O_ZERO);
        cyc("beq_exec", S_EXEC, O_EX_B_T);
        funct3 = 3'b001;
        cyc("bne_fetch", S_FETCH, O_FETCH_W);
        cyc("bne_decode", S_DECODE, O_ZERO);
        cyc("bne_exec", S_EXEC, O_EX_B_N);
        funct3 = 3'b110; alu_zero = 1'b0; alu_ltu = 1'b1;
        cyc("bltu_fetch", S_FETCH, O_FETCH_W);
        cyc("bltu_decode", S_DECODE, O_ZERO);
        cyc("bltu_exec", S_EXEC, O_EX_B_T);
        alu_ltu = 1'b0;
        #1 check_count("branch_count", 32'd6);

        // R-type ADD
        opcode = 7'b0110011; funct3 = 3'b000;
        cyc("r_fetch", S_FETCH, O_FETCH_W);
        cyc("r_decode", S_DECODE, O_ZERO);
        cyc("r_exec", S_EXEC, O_EX_R);
        cyc("r_wb", S_WB, O_WB_ALU);
        #1 check_count("r_count", 32'd7);

        // Illegal opcode: sticky trap, count frozen
        opcode = 7'b1111111;
        cyc("ill_fetch", S_FETCH, O_FETCH_W);
        cyc("ill_decode", S_DECODE, O_ZERO);
        for (int i = 0; i < 100; i++) cyc("ill_trap", S_TRAP, O_TRAP);
        #1 check_count("ill_count_frozen", 32'd7);
        rst_n = 1'b0;
        #1 check_outs("ill_reset", S_IDLE, O_ZERO);
        check_count("ill_reset_count", 32'd0);
        @(negedge clk);

        // B_type with reserved funct3 010
        opcode = 7'b1100011; funct3 = 3'b010;
        rst_n = 1'b1;
        cyc("bres_idle", S_IDLE, O_ZERO);
        cyc("bres_fetch", S_FETCH, O_FETCH_W);
        cyc("bres_decode", S_DECODE, O_ZERO);
        cyc("bres_trap", S_TRAP, O_TRAP);
        cyc("bres_trap2", S_TRAP, O_TRAP);
        rst_n = 1'b0;
        #1 check_outs("bres_reset", S_IDLE, O_ZERO);
        @(negedge clk);

        // Reset asserted mid-MEM on a stalled load: strobes drop at once, no retire
        opcode = 7'b0000011; dmem_ready = 1'b0;
        rst_n = 1'b1;
        cyc("rmem_idle", S_IDLE, O_ZERO);
        cyc("rmem_fetch", S_FETCH, O_FETCH_W);
        cyc("rmem_decode", S_DECODE, O_ZERO);
        cyc("rmem_exec", S_EXEC, O_EX_LS);
        #1 check_outs("rmem_mem", S_MEM, O_MEM_L);
        #2 rst_n = 1'b0;
        #1 check_outs("rmem_reset", S_IDLE, O_ZERO);
        check_count("rmem_count", 32'd0);
        @(negedge clk);
        dmem_ready = 1'b1;

        // Count wraparound via a forced preload, then one BEQ retire
        opcode = 7'b1100011; funct3 = 3'b000; alu_zero = 1'b1;
        rst_n = 1'b1;
        cyc("wrap_idle", S_IDLE, O_ZERO);
        imem_ready = 1'b0;
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1 release dut.retired_count_q;
        check_count("wrap_preload", 32'hFFFF_FFFF);
        @(negedge clk);
        imem_ready = 1'b1;
        cyc("wrap_fetch", S_FETCH, O_FETCH_W);
        cyc("wrap_decode", S_DECODE, O_ZERO);
        cyc("wrap_exec", S_EXEC, O_EX_B_T);
        #1 check_count("wrap_zero", 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
